ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_if.sv | 59 +++++
 rtl/ccff_chain_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
//------------------------------------------------------------------------------
// Module : ccff_chain_loader_if
// Brief  : Bitstream word handshake plus serial ccff chain signals for the
//          configuration chain loader.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ccff_chain_loader_if #(
  parameter int DATA_W = 8
);

  // Load request and bitstream word handshake
  logic              start;
  logic [DATA_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  // Serial chain connection
  logic              ccff_head;
  logic              shift_en;
  logic              ccff_tail;

  // Status
  logic              busy;
  logic              done;
  logic              error;

  // Bitstream source / chain side (drives requests and the chain tail)
  modport master (
    output start,
    output word_in,
    output word_valid,
    output ccff_tail,
    input  word_ready,
    input  ccff_head,
    input  shift_en,
    input  busy,
    input  done,
    input  error
  );

  // Loader side
  modport slave (
    input  start,
    input  word_in,
    input  word_valid,
    input  ccff_tail,
    output word_ready,
    output ccff_head,
    output shift_en,
    output busy,
    output done,
    output error
  );

endinterface

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
//------------------------------------------------------------------------------
// Module : ccff_chain_loader
// Brief  : Serialises a word-wide bitstream MSB-first into a ccff configuration
//          chain, keeps a mirror of the loaded image, then circulates the image
//          once more through the chain to read it back and flag mismatches.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccff_chain_loader #(
  parameter int CHAIN_LEN = 25,
  parameter int DATA_W    = 8
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  ccff_chain_loader_if.slave   io
);

  // Number of words that cover the whole chain; the tail of the last word is
  // surplus and gets dropped.
  localparam int NWORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int HCNT_W = $clog2(DATA_W + 1);
  localparam int WCNT_W = $clog2(NWORDS + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CHAIN_LEN);
  localparam logic [HCNT_W-1:0] HCNT_ZERO = '0;
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_FULL = HCNT_W'(DATA_W);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(NWORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // Datapath registers
  logic [DATA_W-1:0]    hold_reg;   // current word, next bit at the MSB
  logic [HCNT_W-1:0]    hold_cnt;   // bits still waiting in hold_reg
  logic [WCNT_W-1:0]    word_cnt;   // words accepted in this load
  logic [CNT_W-1:0]     bit_cnt;    // shifts done in the current phase
  logic [CHAIN_LEN-1:0] mirror;     // copy of the chain; [CHAIN_LEN-1] is the tail
  logic                 head_q;
  logic                 shift_q;
  logic                 error_q;
  logic                 done_q;

  // Decodes
  logic hold_empty;
  logic hold_last;
  logic load_shift;
  logic load_last;
  logic ready;
  logic word_take;
  logic verify_shift;
  logic verify_cmp;
  logic verify_end;
  logic mirror_tail;

  // Per-cycle decisions for the LOAD and VERIFY phases
  always_comb begin
    hold_empty   = (hold_cnt == HCNT_ZERO);
    hold_last    = (hold_cnt == HCNT_ONE);
    mirror_tail  = mirror[CHAIN_LEN-1];
    load_shift   = (state == ST_LOAD) && !hold_empty;
    load_last    = load_shift && (bit_cnt == CNT_LAST);
    // A word may land on the same edge the final held bit leaves.
    ready        = (state == ST_LOAD) && (hold_empty || hold_last) &&
                   (word_cnt < WCNT_MAX);
    word_take    = ready && io.word_valid;
    verify_shift = (state == ST_VERIFY) && (bit_cnt != CNT_FULL);
    // The chain tail lags the registered head by one cycle, so the first
    // VERIFY cycle has nothing valid to compare and the cycle after the last
    // VERIFY shift does.
    verify_cmp   = (state == ST_VERIFY) && (bit_cnt != CNT_ZERO);
    verify_end   = (state == ST_VERIFY) && (bit_cnt == CNT_FULL);
  end

  // State register
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (io.start) state_nxt = ST_LOAD;
      ST_LOAD:   if (load_last) state_nxt = ST_VERIFY;
      ST_VERIFY: if (verify_end) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Holding register, counters, mirror and registered chain/status outputs
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      hold_reg <= '0;
      hold_cnt <= '0;
      word_cnt <= '0;
      bit_cnt  <= '0;
      mirror   <= '0;
      head_q   <= 1'b0;
      shift_q  <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (io.start) begin
            error_q  <= 1'b0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            hold_reg <= '0;
            word_cnt <= '0;
          end
        end
        ST_LOAD: begin
          // Stall cycles (empty holder) leave head, counter and mirror alone.
          if (load_shift) begin
            head_q   <= hold_reg[DATA_W-1];
            shift_q  <= 1'b1;
            mirror   <= {mirror[CHAIN_LEN-2:0], hold_reg[DATA_W-1]};
            hold_reg <= hold_reg << 1;
            hold_cnt <= hold_cnt - HCNT_ONE;
            bit_cnt  <= bit_cnt + CNT_ONE;
            if (load_last) begin
              // Chain is full: drop the surplus bits of the final word.
              bit_cnt  <= '0;
              hold_cnt <= '0;
            end
          end
          if (word_take) begin
            hold_reg <= io.word_in;
            hold_cnt <= HCNT_FULL;
            word_cnt <= word_cnt + WCNT_ONE;
          end
        end
        ST_VERIFY: begin
          // Recirculate the mirror so the chain ends up with the same image.
          if (verify_shift) begin
            head_q  <= mirror_tail;
            shift_q <= 1'b1;
            mirror  <= {mirror[CHAIN_LEN-2:0], mirror_tail};
            bit_cnt <= bit_cnt + CNT_ONE;
          end
          // head_q still holds the bit expected at the chain tail this cycle.
          if (verify_cmp && (io.ccff_tail != head_q)) begin
            error_q <= 1'b1;
          end
          if (verify_end) begin
            done_q  <= 1'b1;
            bit_cnt <= '0;
          end
        end
        ST_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Output drive
  always_comb begin
    io.word_ready = ready;
    io.ccff_head  = head_q;
    io.shift_en   = shift_q;
    io.busy       = (state == ST_LOAD) || (state == ST_VERIFY);
    io.done       = done_q;
    io.error      = error_q;
  end

endmodule

`default_nettype wire
